// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART transceiver with valid/ready parallel sides.
//   BAUD_DIV  clock cycles per serial bit (>=4)
//   DATA_BITS data bits per frame (5..9)
//   PARITY    0 none, 1 odd, 2 even
//   STOP_BITS stop bits transmitted (1 or 2)
// Ports:
//   clk, reset                  system clock, async active-high reset
//   loopback                    route serial TX into RX internally, tx_out held 1
//   tx_data/tx_valid/tx_ready   transmit word handshake; tx_busy = ~tx_ready
//   tx_out                      serial output pin
//   rx_in                       serial input pin (asynchronous)
//   rx_data/rx_valid/rx_ready   receive word handshake
//   rx_parity_err/rx_frame_err  status of the word in rx_data
//   rx_overrun                  a frame was dropped while rx_valid was set
//
// Both FSMs share one state set:
//   state   | meaning
//   S_IDLE  | line idle, waiting for a word (TX) or a falling edge (RX)
//   S_START | start bit
//   S_DATA  | data bits, LSB first
//   S_PAR   | parity bit (only visited when PARITY != 0)
//   S_STOP  | stop bit(s); RX samples only the first one
module uart_core_param #(
  parameter int BAUD_DIV  = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(BAUD_DIV / 2);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_ser;

  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bad;
  logic                 sync1, sync2;

  assign tx_busy = ~tx_ready;
  // In loopback the pin idles high while the frame travels internally.
  assign tx_out  = loopback | tx_ser;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_ser   <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ PAR_ODD;
            tx_ser   <= 1'b0;
            tx_cnt   <= BIT_LAST;
            tx_ready <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == '0) begin
            tx_ser   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_cnt   <= BIT_LAST;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == DATA_LAST) begin
              tx_idx <= '0;
              if (HAS_PAR) begin
                tx_ser   <= tx_par;
                tx_state <= S_PAR;
              end else begin
                tx_ser   <= 1'b1;
                tx_state <= S_STOP;
              end
            end else begin
              tx_ser   <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_PAR: begin
          if (tx_cnt == '0) begin
            tx_ser   <= 1'b1;
            tx_idx   <= '0;
            tx_cnt   <= BIT_LAST;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_idx == STOP_LAST) begin
              tx_ready <= 1'b1;
              tx_state <= S_IDLE;
            end else begin
              tx_idx <= tx_idx + 1'b1;
              tx_cnt <= BIT_LAST;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // The loopback source goes through the same synchroniser so timing matches the pin path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= loopback ? tx_ser : rx_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      // Handshake first; a delivery on the same edge below overrides these clears.
      if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
        rx_overrun    <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          if (!sync2) begin
            rx_cnt   <= HALF_BIT;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == '0) begin
            if (sync2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_idx   <= '0;
              rx_cnt   <= BIT_LAST;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {sync2, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_idx == DATA_LAST) begin
              rx_state <= HAS_PAR ? S_PAR : S_STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_PAR: begin
          if (rx_cnt == '0) begin
            rx_par_bad <= sync2 ^ (^rx_shift) ^ PAR_ODD;
            rx_cnt     <= BIT_LAST;
            rx_state   <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= S_IDLE;
            if (!rx_valid || rx_ready) begin
              rx_data       <= rx_shift;
              rx_parity_err <= rx_par_bad;
              rx_frame_err  <= ~sync2;
              rx_valid      <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param at BAUD_DIV=4, DATA_BITS=8, even parity, 1 stop bit.
module tb_uart_core_param;
  localparam int BD = 4;
  localparam int FL = 44;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       loopback = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_out;
  logic       rx_in;
  logic       rx_drv = 1'b1;
  logic       wire_back = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_parity_err, rx_frame_err, rx_overrun;

  assign rx_in = wire_back ? tx_out : rx_drv;

  uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .loopback(loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_out(tx_out), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial waveform the frame should produce, one entry per clock cycle.
  function automatic logic [FL-1:0] exp_wave(input logic [7:0] d);
    logic [10:0] bits;
    logic [FL-1:0] w;
    bits = {1'b1, ^d, d, 1'b0};
    for (int i = 0; i < FL; i++) w[i] = bits[i / BD];
    return w;
  endfunction

  task automatic send_ext(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      repeat (BD) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] d);
    @(negedge clk);
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input string name);
    for (int i = 0; i < 80 && !rx_valid; i++) @(negedge clk);
    check(name, rx_valid, 1'b1);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_valid cleared", rx_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic ok;
    logic seen;
    logic [7:0] d;
    logic [FL-1:0] obs;
    logic cp, cs;
    int mode;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset takes effect without a clock edge, and holds.
    #2 reset = 1'b1;
    #1;
    check("rst tx_out", tx_out, 1'b1);
    check("rst tx_ready", tx_ready, 1'b1);
    check("rst tx_busy", tx_busy, 1'b0);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst errs", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
    repeat (5) @(negedge clk);
    check("rst hold", {tx_out, tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err,
                       rx_frame_err, rx_overrun}, {3'b110, 1'b0, 8'h00, 3'b000});
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback of 0xA5.
    loopback = 1'b1;
    send_tx(8'hA5);
    check("lb tx_busy", tx_busy, 1'b1);
    cnt = 0;
    ok  = 1'b1;
    while (!tx_ready && cnt < 100) begin
      cnt++;
      if (tx_out !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("lb busy cycles", cnt, FL);
    check("lb tx_out held", ok, 1'b1);
    wait_rx("lb rx_valid");
    check("lb rx_data", rx_data, 8'hA5);
    check("lb errs", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
    consume();
    loopback = 1'b0;
    repeat (3) @(negedge clk);

    // External frames from the vector table.
    for (int v = 0; v < 7; v++) begin
      send_ext(vecs[v].data, vecs[v].par, vecs[v].stop);
      wait_rx("tbl rx_valid");
      check("tbl rx_data", rx_data, vecs[v].data);
      check("tbl parity_err", rx_parity_err, vecs[v].exp_perr);
      check("tbl frame_err", rx_frame_err, vecs[v].exp_ferr);
      check("tbl overrun", rx_overrun, 1'b0);
      consume();
    end

    // Overrun: second frame dropped while first unread.
    send_ext(8'h11, 1'b0, 1'b1);
    wait_rx("ovr first");
    send_ext(8'h22, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr rx_valid", rx_valid, 1'b1);
    check("ovr rx_data", rx_data, 8'h11);
    check("ovr flag", rx_overrun, 1'b1);
    check("ovr perr", rx_parity_err, 1'b0);
    consume();
    check("ovr cleared", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
    send_ext(8'h33, 1'b0, 1'b1);
    wait_rx("ovr third");
    check("ovr third data", rx_data, 8'h33);
    check("ovr third flag", rx_overrun, 1'b0);
    consume();

    // One-cycle glitch is not a start bit.
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid) seen = 1'b1;
    end
    check("glitch no rx_valid", seen, 1'b0);

    // Reset mid-frame aborts TX and RX.
    loopback = 1'b1;
    repeat (3) @(negedge clk);
    send_tx(8'hFF);
    repeat (19) @(negedge clk);
    check("abort busy before", tx_busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort tx_out", tx_out, 1'b1);
    check("abort tx_ready", tx_ready, 1'b1);
    check("abort tx_busy", tx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid) seen = 1'b1;
    end
    check("abort no rx_valid", seen, 1'b0);
    loopback = 1'b0;
    repeat (3) @(negedge clk);

    // Randomised frames: loopback, pin-wired TX->RX with waveform check, external with errors.
    for (int it = 0; it < 36; it++) begin
      d    = 8'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        loopback = 1'b1;
        repeat (2) @(negedge clk);
        send_tx(d);
        wait_rx("rnd lb rx_valid");
        check("rnd lb data", rx_data, d);
        check("rnd lb errs", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
      end else if (mode == 1) begin
        wire_back = 1'b1;
        repeat (2) @(negedge clk);
        send_tx(d);
        for (int i = 0; i < FL; i++) begin
          obs[i] = tx_out;
          @(negedge clk);
        end
        check("rnd wave", obs, exp_wave(d));
        check("rnd tx_ready back", tx_ready, 1'b1);
        wait_rx("rnd wb rx_valid");
        check("rnd wb data", rx_data, d);
        check("rnd wb errs", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
      end else begin
        cp = ($urandom_range(0, 3) == 0);
        cs = ($urandom_range(0, 3) == 0);
        send_ext(d, (^d) ^ cp, ~cs);
        wait_rx("rnd ext rx_valid");
        check("rnd ext data", rx_data, d);
        check("rnd ext perr", rx_parity_err, cp);
        check("rnd ext ferr", rx_frame_err, cs);
      end
      consume();
      loopback  = 1'b0;
      wire_back = 1'b0;
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
